pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, redirect flushes, front-end freeze.
// Latency: control outputs are combinational in the current cycle; state, remain and stall counter update on the next edge.
// Backpressure: ext_freeze holds the whole front end (all writes low) and freezes the FSM and counter.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   id_rs/id_rt, id_use_rs/rt       ID-stage source registers and read-enables
//   id_branch, id_jump              ID holds a conditional branch / unconditional jump
//   ex_dst/regwrite/memread         EX-stage destination and controls
//   mem_dst/regwrite/memread        MEM-stage destination and controls
//   br_taken                        resolved branch outcome (ID or EX depending on BR_STAGE)
//   ext_freeze                      memory not ready, freeze the front end
//   cnt_clr                         clear the stall counter
//   pc_write, ifid_write/flush,
//   idex_write/flush                pipeline register controls
//   fsm_state                       0 = RUN, 1 = LSTALL
//   stall_cnt                       saturating count of hazard-stall cycles
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_STAGE = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic              br_taken,
  input  logic              ext_freeze,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_flush,
  output logic [1:0]        fsm_state,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1
  } state_t;

  // Branches resolved in EX flush both front-end registers and outrank load-use.
  localparam bit               BR_IN_EX  = (BR_STAGE != 0);
  localparam bit               MULTI_LAT = (LOAD_LAT > 1);
  // The first load-use stall cycle is spent in RUN, so LSTALL covers the rest.
  localparam logic [2:0]       LU_REMAIN = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] remain;
  logic [2:0] remain_nxt;
  logic       cnt_inc;

  logic ex_hit;
  logic mem_hit;
  logic lu;
  logic bh;
  logic rd;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign ex_hit  = (id_use_rs && (id_rs == ex_dst)  && (id_rs != '0)) ||
                   (id_use_rt && (id_rt == ex_dst)  && (id_rt != '0));
  assign mem_hit = (id_use_rs && (id_rs == mem_dst) && (id_rs != '0)) ||
                   (id_use_rt && (id_rt == mem_dst) && (id_rt != '0));

  assign lu = ex_memread && ex_regwrite && ex_hit;

  // A branch compared in ID needs its operands now: any ALU result still in
  // EX, or a load still in MEM, is not yet forwardable.
  assign bh = !BR_IN_EX && id_branch &&
              ((ex_regwrite && ex_hit) ||
               (mem_memread && mem_regwrite && mem_hit));

  assign rd = br_taken || id_jump;

  assign fsm_state = state;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_write = 1'b1;
    idex_flush = 1'b0;
    state_nxt  = state;
    remain_nxt = remain;
    cnt_inc    = 1'b0;

    if (rst) begin
      // Hold the PC and fill the pipeline with bubbles while in reset.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_write = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ext_freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
          end else if (BR_IN_EX && rd) begin
            // The instruction in ID is on the wrong path too: squash both.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu || bh) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            cnt_inc    = 1'b1;
            if (lu && MULTI_LAT) begin
              state_nxt  = LSTALL;
              remain_nxt = LU_REMAIN;
            end
          end else if (rd) begin
            // Branch in ID: only the fetched slot is wrong-path.
            ifid_flush = 1'b1;
          end
        end

        LSTALL: begin
          if (ext_freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
          end else if (BR_IN_EX && br_taken) begin
            // A taken branch in EX makes the stalled consumer wrong-path.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
            remain_nxt = 3'd0;
          end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            cnt_inc    = 1'b1;
            if (remain <= 3'd1) begin
              state_nxt  = RUN;
              remain_nxt = 3'd0;
            end else begin
              remain_nxt = remain - 3'd1;
            end
          end
        end

        default: begin
          state_nxt  = RUN;
          remain_nxt = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      remain    <= 3'd0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (cnt_inc && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with two configurations sharing stimulus.
// Latency: checks combinational controls in-cycle and registered state one edge later.
// Backpressure: exercises ext_freeze in RUN and in LSTALL.
module tb_pipe_hazard_ctrl;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush}
  localparam logic [4:0] C_NORM   = 5'b11010;
  localparam logic [4:0] C_STALL  = 5'b00011;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_RD0    = 5'b11110;
  localparam logic [4:0] C_RD1    = 5'b11111;
  localparam logic [4:0] C_RESET  = 5'b00111;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       id_use_rs, id_use_rt, id_branch, id_jump;
  logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic       br_taken, ext_freeze, cnt_clr;

  // Instance A: LOAD_LAT=1, branch in ID, 16-bit counter
  logic        a_pc, a_ifw, a_iff, a_idw, a_idf;
  logic [1:0]  a_state;
  logic [15:0] a_cnt;
  logic [4:0]  a_ctl;
  // Instance B: LOAD_LAT=3, branch in EX, 4-bit counter
  logic        b_pc, b_ifw, b_iff, b_idw, b_idf;
  logic [1:0]  b_state;
  logic [3:0]  b_cnt;
  logic [4:0]  b_ctl;

  int checks = 0;
  int errors = 0;

  assign a_ctl = {a_pc, a_ifw, a_iff, a_idw, a_idf};
  assign b_ctl = {b_pc, b_ifw, b_iff, b_idw, b_idf};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_STAGE(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_jump(id_jump),
    .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .br_taken(br_taken), .ext_freeze(ext_freeze), .cnt_clr(cnt_clr),
    .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_iff),
    .idex_write(a_idw), .idex_flush(a_idf),
    .fsm_state(a_state), .stall_cnt(a_cnt)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_STAGE(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_jump(id_jump),
    .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .br_taken(br_taken), .ext_freeze(ext_freeze), .cnt_clr(cnt_clr),
    .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_iff),
    .idex_write(b_idw), .idex_flush(b_idf),
    .fsm_state(b_state), .stall_cnt(b_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_branch = 0; id_jump = 0;
    ex_dst = '0; ex_regwrite = 0; ex_memread = 0;
    mem_dst = '0; mem_regwrite = 0; mem_memread = 0;
    br_taken = 0; ext_freeze = 0; cnt_clr = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  // Load into r5 in EX, ID reads r5 as rs.
  task automatic apply_lu;
    ex_memread = 1; ex_regwrite = 1; ex_dst = 5'd5;
    id_rs = 5'd5; id_use_rs = 1;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    #1;
    checks++; if (a_ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl_a got %b want %b", a_ctl, C_RESET); end
    checks++; if (b_ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl_b got %b want %b", b_ctl, C_RESET); end
    tick();
    tick();
    checks++; if (a_state !== 2'd0 || a_cnt !== 16'd0) begin errors++; $display("FAIL reset_state_a got st=%0d cnt=%0d want 0 0", a_state, a_cnt); end
    checks++; if (b_state !== 2'd0 || b_cnt !== 4'd0) begin errors++; $display("FAIL reset_state_b got st=%0d cnt=%0d want 0 0", b_state, b_cnt); end
    rst = 0;
    #1;
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL post_reset_norm got %b want %b", a_ctl, C_NORM); end
  endtask

  task automatic test_lu_lat1;
    do_reset();
    apply_lu();
    #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL lu1_ctl got %b want %b", a_ctl, C_STALL); end
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL lu1_cnt_before got %0d want 0", a_cnt); end
    tick();
    idle_inputs();
    #1;
    checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL lu1_cnt_after got %0d want 1", a_cnt); end
    checks++; if (a_state !== 2'd0 || a_ctl !== C_NORM) begin errors++; $display("FAIL lu1_resume got st=%0d ctl=%b want 0 %b", a_state, a_ctl, C_NORM); end
  endtask

  task automatic test_lu_lat3;
    do_reset();
    apply_lu();
    #1;
    checks++; if (b_ctl !== C_STALL || b_state !== 2'd0) begin errors++; $display("FAIL lu3_c1 got ctl=%b st=%0d want %b 0", b_ctl, b_state, C_STALL); end
    tick();
    idle_inputs();
    #1;
    checks++; if (b_ctl !== C_STALL || b_state !== 2'd1 || b_cnt !== 4'd1) begin errors++; $display("FAIL lu3_c2 got ctl=%b st=%0d cnt=%0d want %b 1 1", b_ctl, b_state, b_cnt, C_STALL); end
    tick();
    checks++; if (b_ctl !== C_STALL || b_state !== 2'd1 || b_cnt !== 4'd2) begin errors++; $display("FAIL lu3_c3 got ctl=%b st=%0d cnt=%0d want %b 1 2", b_ctl, b_state, b_cnt, C_STALL); end
    tick();
    checks++; if (b_ctl !== C_NORM || b_state !== 2'd0 || b_cnt !== 4'd3) begin errors++; $display("FAIL lu3_done got ctl=%b st=%0d cnt=%0d want %b 0 3", b_ctl, b_state, b_cnt, C_NORM); end
  endtask

  task automatic test_no_hazard;
    do_reset();
    ex_memread = 1; ex_regwrite = 1; ex_dst = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    #1;
    checks++; if (a_ctl !== C_NORM || b_ctl !== C_NORM) begin errors++; $display("FAIL r0_nostall got a=%b b=%b want %b", a_ctl, b_ctl, C_NORM); end
    ex_dst = 5'd5; id_rs = 5'd5; id_use_rs = 0;
    #1;
    checks++; if (a_ctl !== C_NORM) begin errors++; $display("FAIL unused_src got %b want %b", a_ctl, C_NORM); end
    tick();
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL nohaz_cnt got %0d want 0", a_cnt); end
  endtask

  task automatic test_branch_hazard;
    do_reset();
    id_branch = 1; id_rt = 5'd7; id_use_rt = 1; ex_dst = 5'd7; ex_regwrite = 1;
    #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL bh_ex_a got %b want %b", a_ctl, C_STALL); end
    checks++; if (b_ctl !== C_NORM) begin errors++; $display("FAIL bh_brstage1_b got %b want %b", b_ctl, C_NORM); end
    tick();
    ex_regwrite = 0; ex_dst = 5'd0; br_taken = 1;
    #1;
    checks++; if (a_state !== 2'd0 || a_cnt !== 16'd1) begin errors++; $display("FAIL bh_one_cycle got st=%0d cnt=%0d want 0 1", a_state, a_cnt); end
    checks++; if (a_ctl !== C_RD0) begin errors++; $display("FAIL rd_id_a got %b want %b", a_ctl, C_RD0); end
    checks++; if (b_ctl !== C_RD1) begin errors++; $display("FAIL rd_ex_b got %b want %b", b_ctl, C_RD1); end
    br_taken = 0; mem_memread = 1; mem_regwrite = 1; mem_dst = 5'd7;
    #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL bh_mem_a got %b want %b", a_ctl, C_STALL); end
    // Load-use together with a jump: stall wins in ID mode, redirect wins in EX mode.
    idle_inputs();
    apply_lu();
    id_jump = 1;
    #1;
    checks++; if (a_ctl !== C_STALL) begin errors++; $display("FAIL prio_lu_over_rd_a got %b want %b", a_ctl, C_STALL); end
    checks++; if (b_ctl !== C_RD1) begin errors++; $display("FAIL prio_rd_over_lu_b got %b want %b", b_ctl, C_RD1); end
  endtask

  task automatic test_lstall_abort;
    do_reset();
    apply_lu();
    tick();
    idle_inputs();
    br_taken = 1;
    #1;
    checks++; if (b_state !== 2'd1 || b_ctl !== C_RD1) begin errors++; $display("FAIL abort_ctl got st=%0d ctl=%b want 1 %b", b_state, b_ctl, C_RD1); end
    tick();
    br_taken = 0;
    #1;
    checks++; if (b_state !== 2'd0 || b_cnt !== 4'd1 || b_ctl !== C_NORM) begin errors++; $display("FAIL abort_run got st=%0d cnt=%0d ctl=%b want 0 1 %b", b_state, b_cnt, b_ctl, C_NORM); end
  endtask

  task automatic test_freeze;
    do_reset();
    apply_lu();
    tick();
    idle_inputs();
    ext_freeze = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (b_ctl !== C_FREEZE || b_state !== 2'd1 || b_cnt !== 4'd1) begin errors++; $display("FAIL freeze_lstall[%0d] got ctl=%b st=%0d cnt=%0d want %b 1 1", i, b_ctl, b_state, b_cnt, C_FREEZE); end
      tick();
    end
    checks++; if (a_ctl !== C_FREEZE) begin errors++; $display("FAIL freeze_run_a got %b want %b", a_ctl, C_FREEZE); end
    ext_freeze = 0;
    #1;
    checks++; if (b_ctl !== C_STALL || b_state !== 2'd1) begin errors++; $display("FAIL thaw_c2 got ctl=%b st=%0d want %b 1", b_ctl, b_state, C_STALL); end
    tick();
    checks++; if (b_state !== 2'd1 || b_cnt !== 4'd2) begin errors++; $display("FAIL thaw_c3 got st=%0d cnt=%0d want 1 2", b_state, b_cnt); end
    tick();
    checks++; if (b_state !== 2'd0 || b_cnt !== 4'd3) begin errors++; $display("FAIL thaw_done got st=%0d cnt=%0d want 0 3", b_state, b_cnt); end
  endtask

  task automatic test_saturate;
    do_reset();
    apply_lu();
    for (int i = 0; i < 20; i++) tick();
    checks++; if (b_cnt !== 4'd15) begin errors++; $display("FAIL sat_b got %0d want 15", b_cnt); end
    checks++; if (a_cnt !== 16'd20) begin errors++; $display("FAIL count_a got %0d want 20", a_cnt); end
    idle_inputs();
  endtask

  task automatic test_back_to_back_reset_clr;
    do_reset();
    apply_lu();
    tick();
    idle_inputs();
    #1;
    checks++; if (b_state !== 2'd1) begin errors++; $display("FAIL pre_rst_lstall got %0d want 1", b_state); end
    rst = 1;
    #1;
    checks++; if (b_ctl !== C_RESET) begin errors++; $display("FAIL rst_mid_ctl got %b want %b", b_ctl, C_RESET); end
    tick();
    rst = 0;
    #1;
    checks++; if (b_state !== 2'd0 || b_cnt !== 4'd0 || b_ctl !== C_NORM) begin errors++; $display("FAIL rst_mid got st=%0d cnt=%0d ctl=%b want 0 0 %b", b_state, b_cnt, b_ctl, C_NORM); end
    // Clear concurrent with stall cycles.
    apply_lu();
    tick();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    idle_inputs();
    #1;
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL clr_a got %0d want 0", a_cnt); end
    checks++; if (b_cnt !== 4'd0 || b_state !== 2'd1) begin errors++; $display("FAIL clr_b got cnt=%0d st=%0d want 0 1", b_cnt, b_state); end
    tick();
    checks++; if (b_cnt !== 4'd1 || b_state !== 2'd0) begin errors++; $display("FAIL clr_b_after got cnt=%0d st=%0d want 1 0", b_cnt, b_state); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_lu_lat1();
    test_lu_lat3();
    test_no_hazard();
    test_branch_hazard();
    test_lstall_abort();
    test_freeze();
    test_saturate();
    test_back_to_back_reset_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
